// File: rtl/output_writer.sv
// Output writer: requantizes signed adder results to OUT_W-bit ReLU-clamped values
// and streams them into the output memory, one tile of NUM_OUT words at a time.
module output_writer #(
   parameter int DATA_W    = 32,
   parameter int OUT_W     = 8,
   parameter int NUM_OUT   = 16,
   parameter int NUM_TILES = 4,
   parameter int SHIFT     = 8,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              layer_start,
   input  logic              write_start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              mem_stall,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [OUT_W-1:0]  mem_wdata,
   output logic              write_output_done,
   output logic              is_last,
   output logic              busy
);

   localparam int EW = $clog2(NUM_OUT + 1);
   localparam int TW = $clog2(NUM_TILES + 1);
   localparam logic [EW-1:0] L_NOUT = EW'(NUM_OUT);
   localparam logic [TW-1:0] L_TMAX = TW'(NUM_TILES);
   localparam logic signed [DATA_W-1:0] L_QMAX = DATA_W'((2 ** (OUT_W - 1)) - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [OUT_W-1:0] fn_requant(input logic signed [DATA_W-1:0] d);
      logic signed [DATA_W-1:0] q;
      q = d >>> SHIFT;
      if (q < 0)
         fn_requant = '0;
      else if (q > L_QMAX)
         fn_requant = L_QMAX[OUT_W-1:0];
      else
         fn_requant = q[OUT_W-1:0];
   endfunction

   state_t                   r_state;
   state_t                   w_next;
   logic                     w_start;
   logic [EW-1:0]            r_elem_cnt;
   logic [TW-1:0]            r_tile_cnt;
   logic                     r_is_last;
   logic                     r_we_p1;
   logic [ADDR_W-1:0]        r_addr_p1;
   logic [OUT_W-1:0]         r_wdata_p1;

   logic signed [DATA_W-1:0] w_in_s;
   logic                     w_stall_hold;
   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_wr_done;
   logic                     w_last_done;
   logic [ADDR_W-1:0]        w_addr;

   assign w_in_s       = in_data;
   assign w_stall_hold = r_we_p1 && mem_stall;
   assign w_in_ready   = (r_state == RUN) && (r_elem_cnt < L_NOUT) && !w_stall_hold;
   // layer_start aborts the tile, so a beat offered in the same cycle is dropped
   assign w_accept     = w_in_ready && in_valid && !layer_start;
   assign w_wr_done    = r_we_p1 && !mem_stall;
   // With at most one write outstanding, the write in flight once all beats are in is the last one
   assign w_last_done  = (r_state == RUN) && w_wr_done && (r_elem_cnt == L_NOUT);
   assign w_addr       = ADDR_W'(int'(r_tile_cnt) * NUM_OUT + int'(r_elem_cnt));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      if (layer_start) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (write_start && !r_is_last) begin
                  w_next  = RUN;
                  w_start = 1'b1;
               end
            end
            RUN: begin
               if (w_last_done)
                  w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_elem_cnt <= '0;
         r_tile_cnt <= '0;
         r_is_last  <= 1'b0;
      end else if (layer_start) begin
         r_elem_cnt <= '0;
         r_tile_cnt <= '0;
         r_is_last  <= 1'b0;
      end else begin
         if (w_start)
            r_elem_cnt <= '0;
         else if (w_accept)
            r_elem_cnt <= r_elem_cnt + 1'b1;
         if ((r_state == DONE) && (r_tile_cnt < L_TMAX)) begin
            r_tile_cnt <= r_tile_cnt + 1'b1;
            r_is_last  <= ((r_tile_cnt + 1'b1) == L_TMAX);
         end
      end
   end

   // write stage: one cycle after acceptance, held while the memory stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_we_p1    <= 1'b0;
         r_addr_p1  <= '0;
         r_wdata_p1 <= '0;
      end else if (layer_start) begin
         r_we_p1 <= 1'b0;
      end else if (w_accept) begin
         r_we_p1    <= 1'b1;
         r_addr_p1  <= w_addr;
         r_wdata_p1 <= fn_requant(w_in_s);
      end else if (w_wr_done) begin
         r_we_p1 <= 1'b0;
      end
   end

   assign in_ready          = w_in_ready;
   assign mem_we            = r_we_p1;
   assign mem_addr          = r_addr_p1;
   assign mem_wdata         = r_wdata_p1;
   assign write_output_done = (r_state == DONE);
   assign is_last           = r_is_last;
   assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_output_writer.sv
// Scoreboard bench for output_writer: a reference model queues expected writes,
// a monitor pops and compares every completed memory write.
module tb_output_writer;

   localparam int DATA_W    = 32;
   localparam int OUT_W     = 8;
   localparam int NUM_OUT   = 16;
   localparam int NUM_TILES = 4;
   localparam int SHIFT     = 8;
   localparam int ADDR_W    = 8;

   logic              clk;
   logic              rstn;
   logic              layer_start;
   logic              write_start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              mem_stall;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [OUT_W-1:0]  mem_wdata;
   logic              write_output_done;
   logic              is_last;
   logic              busy;

   output_writer #(
      .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_OUT(NUM_OUT),
      .NUM_TILES(NUM_TILES), .SHIFT(SHIFT), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rstn(rstn), .layer_start(layer_start), .write_start(write_start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mem_stall(mem_stall), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .write_output_done(write_output_done),
      .is_last(is_last), .busy(busy)
   );

   typedef struct {
      int addr;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   m_tile = 0;
   int   m_elem = 0;
   int   wr_count = 0;
   int   done_cnt = 0;
   int   hold_cnt = 0;
   int   trig_addr = -1;
   bit   trig_fired = 0;
   int   stall_left = 0;
   bit   stall_rand = 0;
   logic [31:0] dir_data [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference requantizer: arithmetic shift, ReLU, clamp to the largest positive code
   function automatic int model_q(input logic [31:0] d);
      int s;
      int q;
      s = $signed(d);
      q = s >>> SHIFT;
      if (q < 0) return 0;
      if (q > (2 ** (OUT_W - 1)) - 1) return (2 ** (OUT_W - 1)) - 1;
      return q;
   endfunction

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 32767));
         2:       return 32'(-int'($urandom_range(1, 100000)));
         default: return 32'($urandom_range(32000, 33000));
      endcase
   endfunction

   // memory-side stall generator: random, or a fixed 3-cycle stall on one address
   initial begin
      mem_stall = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_rand) begin
            mem_stall = ($urandom_range(0, 3) == 0);
         end else if (stall_left > 0) begin
            mem_stall = 1'b1;
            stall_left--;
         end else if (trig_addr >= 0 && !trig_fired && mem_we === 1'b1 && int'(mem_addr) == trig_addr) begin
            mem_stall  = 1'b1;
            stall_left = 2;
            trig_fired = 1;
         end else begin
            mem_stall = 1'b0;
         end
      end
   end

   initial begin : monitor
      bit            p_hold;
      logic [ADDR_W-1:0] p_addr;
      logic [OUT_W-1:0]  p_data;
      exp_t          e;
      p_hold = 0;
      p_addr = '0;
      p_data = '0;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1) begin
            if (mem_we === 1'b1 && mem_stall === 1'b1)
               chk("ready_during_stall", in_ready, 0);
            if (p_hold) begin
               chk("stall_hold_we", mem_we, 1);
               chk("stall_hold_addr", mem_addr, p_addr);
               chk("stall_hold_data", mem_wdata, p_data);
            end
            p_hold = (mem_we === 1'b1 && mem_stall === 1'b1);
            p_addr = mem_addr;
            p_data = mem_wdata;
            if (trig_addr >= 0 && mem_we === 1'b1 && int'(mem_addr) == trig_addr)
               hold_cnt++;
            if (mem_we === 1'b1 && mem_stall === 1'b0) begin
               wr_count++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write actual_addr=%0d actual_data=%0d required=no_write", mem_addr, mem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", mem_addr, e.addr);
                  chk("wr_data", mem_wdata, e.data);
               end
            end
            if (write_output_done === 1'b1)
               done_cnt++;
         end else begin
            p_hold = 0;
         end
      end
   end

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ws();
      write_start = 1'b1;
      next_cycle();
      write_start = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d);
      bit   acc;
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      acc = 0;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         acc = (in_ready === 1'b1);
         next_cycle();
      end
      in_valid = 1'b0;
      chk("beat_accepted", acc, 1);
      if (acc) begin
         e.addr = m_tile * NUM_OUT + m_elem;
         e.data = model_q(d);
         exp_q.push_back(e);
         m_elem++;
      end
   endtask

   // back-to-back tile with no stalls: exact cycle timing of writes, done and busy
   task automatic run_tile_tight(input bit directed);
      int wr0;
      m_elem = 0;
      pulse_ws();
      wr0 = wr_count;
      for (int i = 0; i < NUM_OUT; i++)
         send_beat((directed && i < 4) ? dir_data[i] : rand_data());
      sample();
      chk("tight_consecutive_writes", wr_count - wr0, NUM_OUT);
      chk("tight_last_addr", mem_addr, m_tile * NUM_OUT + NUM_OUT - 1);
      chk("tight_done_early", write_output_done, 0);
      sample();
      chk("tight_done_pulse", write_output_done, 1);
      chk("tight_we_in_done", mem_we, 0);
      chk("tight_busy_in_done", busy, 1);
      chk("tight_is_last_in_done", is_last, 0);
      sample();
      chk("tight_done_once", write_output_done, 0);
      chk("tight_busy_fall", busy, 0);
      chk("tight_is_last", is_last, (m_tile == NUM_TILES - 1) ? 1 : 0);
      m_tile++;
      next_cycle();
   endtask

   task automatic run_tile_rand(input int gap_max);
      bit seen;
      m_elem = 0;
      pulse_ws();
      for (int i = 0; i < NUM_OUT; i++) begin
         repeat ($urandom_range(0, gap_max)) next_cycle();
         send_beat(rand_data());
      end
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         sample();
         seen = (write_output_done === 1'b1);
      end
      chk("rand_done_seen", seen, 1);
      sample();
      chk("rand_busy_after_done", busy, 0);
      chk("rand_is_last", is_last, (m_tile == NUM_TILES - 1) ? 1 : 0);
      chk("rand_queue_drained", exp_q.size(), 0);
      m_tile++;
      next_cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      dir_data[0] = 32'h0000_1234;
      dir_data[1] = 32'hFFFF_FE0C;
      dir_data[2] = 32'h0001_0000;
      dir_data[3] = 32'h0000_7F80;
      rstn = 1'b0;
      layer_start = 1'b0;
      write_start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;

      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_done", write_output_done, 0);
      chk("rst_is_last", is_last, 0);
      chk("rst_busy", busy, 0);
      next_cycle();
      rstn = 1'b1;
      sample();
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 0);
      next_cycle();

      run_tile_tight(1);

      trig_addr = m_tile * NUM_OUT + 4;
      trig_fired = 0;
      hold_cnt = 0;
      run_tile_rand(0);
      chk("stall_addr_held_cycles", hold_cnt, 4);
      trig_addr = -1;

      run_tile_rand(2);
      stall_rand = 1;
      run_tile_rand(2);
      stall_rand = 0;
      next_cycle();
      chk("is_last_after_4_tiles", is_last, 1);

      in_valid = 1'b1;
      in_data = rand_data();
      pulse_ws();
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("fifth_ws_ignored", busy, 0);
      end
      in_valid = 1'b0;
      next_cycle();

      layer_start = 1'b1;
      next_cycle();
      layer_start = 1'b0;
      sample();
      chk("layer_start_clears_last", is_last, 0);
      m_tile = 0;
      next_cycle();

      layer_start = 1'b1;
      write_start = 1'b1;
      next_cycle();
      layer_start = 1'b0;
      write_start = 1'b0;
      sample();
      chk("ls_wins_over_ws", busy, 0);
      next_cycle();

      run_tile_tight(0);

      m_elem = 0;
      pulse_ws();
      for (int i = 0; i < 7; i++) send_beat(rand_data());
      repeat (2) next_cycle();
      chk("pre_reset_drained", exp_q.size(), 0);
      chk("pre_reset_busy", busy, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_addr", mem_addr, 0);
      chk("async_rst_data", mem_wdata, 0);
      chk("async_rst_we", mem_we, 0);
      chk("async_rst_ready", in_ready, 0);
      chk("async_rst_done", write_output_done, 0);
      chk("async_rst_is_last", is_last, 0);
      exp_q.delete();
      m_tile = 0;
      next_cycle();
      rstn = 1'b1;
      next_cycle();
      run_tile_tight(0);

      m_elem = 0;
      pulse_ws();
      for (int i = 0; i < 3; i++) send_beat(rand_data());
      layer_start = 1'b1;
      next_cycle();
      layer_start = 1'b0;
      d0 = done_cnt;
      sample();
      chk("abort_we_low", mem_we, 0);
      chk("abort_idle", busy, 0);
      repeat (3) sample();
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_queue_drained", exp_q.size(), 0);
      m_tile = 0;
      next_cycle();
      run_tile_tight(0);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/output_writer.md
OUTPUT_WRITER -- requirements
Module: output_writer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (ports clk and rstn).
REQ-002 Parameters SHALL be, one per line:
- DATA_W, 32, signed accumulator width from the adder.
- OUT_W, 8, stored output width.
- NUM_OUT, 16, outputs per tile.
- NUM_TILES, 4, tiles per layer.
- SHIFT, 8, requantization right-shift.
- ADDR_W, 8, output memory address width.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- layer_start  in  1  one-cycle pulse; starts a new layer and clears the tile count.
- write_start  in  1  one-cycle pulse; starts writing one tile.
- in_valid  in  1  adder result valid.
- in_ready  out  1  block accepts in_data.
- in_data  in  DATA_W  signed adder result.
- mem_stall  in  1  output memory cannot take a write this cycle.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  OUT_W  write data.
- write_output_done  out  1  one-cycle pulse; tile fully written.
- is_last  out  1  level; all NUM_TILES tiles of the layer are written.
- busy  out  1  state != IDLE.

Function
REQ-004 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-005 IDLE -> RUN SHALL occur on write_start when is_last=0, clearing elem_cnt.
- write_start SHALL be ignored outside IDLE.
- write_start SHALL be ignored when is_last=1.
REQ-006 RUN: in_ready SHALL equal (elem_cnt < NUM_OUT) && !(mem_we && mem_stall).
- A beat is accepted when in_valid && in_ready.
REQ-007 An accepted beat SHALL be quantized as q = in_data >>> SHIFT (arithmetic).
- q < 0 SHALL give 0 (ReLU).
- q > 2^(OUT_W-1)-1 SHALL give 2^(OUT_W-1)-1.
- Otherwise the result SHALL be q[OUT_W-1:0].
REQ-008 Write timing:
- Next cycle: mem_we=1, mem_addr=tile_cnt*NUM_OUT+elem_cnt, mem_wdata=quantized value; elem_cnt increments.
- Latency is one cycle from acceptance to mem_we.
REQ-009 A write SHALL complete in a cycle with mem_we=1 && mem_stall=0.
- While mem_stall=1, mem_we/mem_addr/mem_wdata SHALL hold unchanged.
- No beat SHALL be lost or duplicated.
REQ-010 Back-to-back accepts with mem_stall=0 SHALL sustain one write per cycle.
REQ-011 RUN -> DONE SHALL occur when the NUM_OUT-th write completes; mem_we=0 in DONE.
REQ-012 DONE SHALL last exactly one cycle:
- write_output_done=1 during DONE.
- tile_cnt increments on exit.
- Next state is IDLE.
REQ-013 tile_cnt SHALL be clog2(NUM_TILES+1) bits wide, ranging 0..NUM_TILES with no wrap.
- is_last SHALL equal (tile_cnt == NUM_TILES), registered.
- is_last is therefore high from the cycle after the final done pulse.
REQ-014 layer_start SHALL in any state:
- set tile_cnt=0, elem_cnt=0, is_last=0 and mem_we=0;
- force the state to IDLE, aborting any tile in progress.
REQ-015 If layer_start and write_start arrive in the same cycle, layer_start SHALL win and write_start SHALL be ignored.
REQ-016 in_ready SHALL be 0 in IDLE and DONE.
- in_valid outside RUN SHALL have no effect.

Reset
REQ-017 rstn low SHALL asynchronously force:
- state=IDLE;
- elem_cnt=0 and tile_cnt=0;
- in_ready, mem_we, mem_addr, mem_wdata, write_output_done, is_last and busy all 0.
REQ-018 After rstn deasserts, the block SHALL wait in IDLE for write_start.

Verification
REQ-019 Quantize:
- in_data 0x00001234 -> mem_wdata 0x12.
- in_data -500 -> 0x00.
- in_data 0x00010000 -> 0x7F.
- in_data 0x00007F80 -> 0x7F.
REQ-020 Full tile, mem_stall=0: write_start, then 16 back-to-back beats ->
- mem_addr 0..15 on 16 consecutive cycles;
- write_output_done pulses once, the cycle after the last write;
- busy falls the cycle after that.
REQ-021 mem_stall high for 3 cycles during the 5th write ->
- mem_addr=4 and its data held for 4 cycles;
- in_ready=0 during the stall;
- the address sequence continues 5..15 with no gaps or repeats.
REQ-022 Four tiles ->
- addresses 0..63 written;
- is_last=1 the cycle after the 4th done pulse;
- a 5th write_start is ignored;
- layer_start clears is_last and the next tile writes from address 0.
REQ-023 rstn pulsed low after 7 writes of tile 1 ->
- all outputs go to 0 immediately;
- the next write_start writes from address 0.
REQ-024 layer_start mid-tile (after 3 writes) ->
- mem_we=0 the next cycle and the state returns to IDLE;
- no write_output_done pulse;
- tile_cnt=0.
